// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

endpackage : demux_pkg

// File: rtl/demux_1x4_stream_chan_fifo.sv
// Per-channel synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart without an occupancy counter.
module chan_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head entry straight from storage; forced to zero while empty so the
    // output is clean after reset without having to clear the array.
    assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Next pointers and next storage contents.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately not reset; equal pointers mark it empty and dout masks it.
        mem_q <= mem_d;
    end

endmodule : chan_fifo

// File: rtl/demux_1x4_stream.sv
// 1-to-4 stream demultiplexer: steers each input beat into the FIFO of the
// channel named by in_sel and counts beats delivered on each channel.
module demux_1x4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  ch_sel_t                  in_sel,
    input  logic [DATA_W-1:0]        in_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH*CNT_W-1:0]  out_count
);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [CNT_W-1:0]  count_q [NUM_CH];
    logic [CNT_W-1:0]  count_d [NUM_CH];

    // Acceptance depends only on the selected FIFO's fullness, never on
    // out_ready, so a full channel stalls even if it pops this cycle.
    assign in_ready = ~full[in_sel];

    // One-hot push decode for the selected channel.
    always_comb begin
        push = '0;
        if (in_valid && in_ready) begin
            push[in_sel] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (in_data),
            .dout  (out_data[g*DATA_W +: DATA_W]),
            .full  (full[g]),
            .empty (empty[g])
        );

        assign out_valid[g]                 = ~empty[g];
        assign pop[g]                       = ~empty[g] & out_ready[g];
        assign out_count[g*CNT_W +: CNT_W]  = count_q[g];
    end

    // Delivered-beat counters; wrap naturally at 2^CNT_W.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            count_d[i] = count_q[i];
            if (pop[i]) begin
                count_d[i] = count_q[i] + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

endmodule : demux_1x4_stream

// File: tb/tb_demux_1x4_stream.sv
// Self-checking bench for demux_1x4_stream against a queue-based model.
module tb_demux_1x4_stream;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 4;
    localparam int NCH    = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [1:0]             in_sel = 2'd0;
    logic [DATA_W-1:0]      in_data = '0;
    logic [NCH-1:0]         out_valid;
    logic [NCH-1:0]         out_ready = '0;
    logic [NCH*DATA_W-1:0]  out_data;
    logic [NCH*CNT_W-1:0]   out_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue per channel plus a delivered count.
    logic [DATA_W-1:0] mq [NCH][$];
    int                mcnt [NCH];

    demux_1x4_stream #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            mq[i].delete();
            mcnt[i] = 0;
        end
    endtask

    // Compare every output with the model at the negedge, then advance the
    // model across the following rising edge. Returns whether a beat was taken.
    task automatic step(output bit accepted);
        bit [NCH-1:0] exp_pop;
        bit           exp_push;
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("valid%0d", i), 32'(out_valid[i]), 32'(mq[i].size() != 0));
            check($sformatf("data%0d", i), 32'(out_data[i*DATA_W +: DATA_W]),
                  (mq[i].size() != 0) ? 32'(mq[i][0]) : 32'd0);
            check($sformatf("count%0d", i), 32'(out_count[i*CNT_W +: CNT_W]),
                  32'(mcnt[i] % (1 << CNT_W)));
            exp_pop[i] = (mq[i].size() != 0) && out_ready[i];
        end
        check("in_ready", 32'(in_ready), 32'(mq[in_sel].size() < DEPTH));
        exp_push = in_valid && (mq[in_sel].size() < DEPTH);
        @(posedge clk);
        for (int i = 0; i < NCH; i++) begin
            if (exp_pop[i]) begin
                void'(mq[i].pop_front());
                mcnt[i]++;
            end
        end
        if (exp_push) mq[in_sel].push_back(in_data);
        accepted = exp_push;
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [DATA_W-1:0] d, output bit acc);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        step(acc);
        in_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        int beats;
        int cycles;
        model_clear();
        #12 rst = 1'b0;
        @(posedge clk); #1;

        // Routing: one beat per channel, all consumers ready.
        out_ready = 4'hF;
        for (int i = 0; i < NCH; i++) begin
            send(2'(i), 8'hA0 + 8'(i), acc);
            check($sformatf("route_acc%0d", i), 32'(acc), 32'd1);
        end
        step(acc);
        step(acc);
        for (int i = 0; i < NCH; i++)
            check($sformatf("route_cnt%0d", i), 32'(out_count[i*CNT_W +: CNT_W]), 32'd1);

        // Backpressure on channel 2; channel 1 keeps flowing.
        out_ready = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            send(2'd2, 8'hC0 + 8'(i), acc);
            check($sformatf("bp_acc%0d", i), 32'(acc), (i < DEPTH) ? 32'd1 : 32'd0);
        end
        send(2'd1, 8'h11, acc);
        check("bp_ch1_acc", 32'(acc), 32'd1);
        step(acc);
        out_ready = 4'hF;
        for (int i = 0; i < 3; i++) step(acc);

        // Same-cycle push and pop on channel 0.
        out_ready = 4'h0;
        send(2'd0, 8'h33, acc);
        out_ready = 4'h1;
        send(2'd0, 8'h55, acc);
        check("pp_acc", 32'(acc), 32'd1);
        out_ready = 4'h0;
        step(acc);
        check("pp_valid", 32'(out_valid[0]), 32'd1);
        check("pp_head", 32'(out_data[7:0]), 32'h55);
        check("pp_occ", 32'(mq[0].size()), 32'd1);

        // Reset mid-stream with buffered beats.
        send(2'd3, 8'h77, acc);
        send(2'd3, 8'h78, acc);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Random traffic; a stalled beat is held until accepted.
        beats  = 0;
        cycles = 0;
        acc    = 1'b1;
        while (beats < 1000 && cycles < 20000) begin
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = 8'($urandom);
            end
            out_ready = 4'($urandom);
            step(acc);
            if (acc) beats++;
            cycles++;
        end
        check("rand_done", 32'(beats), 32'd1000);
        in_valid  = 1'b0;
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) step(acc);
        for (int i = 0; i < NCH; i++)
            check($sformatf("drain%0d", i), 32'(mq[i].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux_1x4_stream
